// File: rtl/seq_pkg.sv
// Shared constants and helpers for the serial pattern detector.
package seq_pkg;

  localparam int unsigned LEN_MIN = 2;
  localparam int unsigned LEN_MAX = 32;

  function automatic int unsigned fill_width(input int unsigned len);
    return (len <= 2) ? 1 : $clog2(len);
  endfunction

  typedef logic [$clog2(LEN_MAX)-1:0] fill_max_t;

endpackage

// File: rtl/seq_sat_counter.sv
// Saturating up-counter; sat is registered alongside the count.
module seq_sat_counter #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt,
  output logic             sat
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sat_q, sat_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
    sat_d = (cnt_d == '1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      sat_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sat_q <= sat_d;
    end
  end

  assign cnt = cnt_q;
  assign sat = sat_q;

endmodule

// File: rtl/seq_pattern_fsm.sv
// Runtime-pattern serial detector; fill (0..LEN-1) is the FSM state.
module seq_pattern_fsm
  import seq_pkg::*;
#(
  parameter int unsigned LEN     = 4,
  parameter int unsigned OVERLAP = 1,
  parameter int unsigned MEALY   = 1,
  parameter int unsigned CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             din_valid,
  input  logic             din,
  input  logic [LEN-1:0]   pattern,
  output logic             match,
  output logic [CNT_W-1:0] match_cnt,
  output logic             cnt_sat
);

  localparam int unsigned FW = fill_width(LEN);
  typedef logic [FW-1:0] fill_t;
  localparam fill_t FILL_TOP = fill_t'(LEN - 1);

  logic [LEN-2:0] hist_q, hist_d;
  fill_t          fill_q, fill_d;
  logic           match_q;
  logic [LEN-1:0] win;
  logic           hit;

  // win[LEN-2:0] is the shifted history, which also covers LEN=2 without a special case
  always_comb begin
    win    = {hist_q, din};
    hit    = !rst && !clr && din_valid && (fill_q == FILL_TOP) && (win == pattern);
    hist_d = hist_q;
    fill_d = fill_q;
    if (clr) begin
      hist_d = '0;
      fill_d = '0;
    end else if (din_valid) begin
      if (hit && (OVERLAP == 0)) begin
        hist_d = '0;
        fill_d = '0;
      end else begin
        hist_d = win[LEN-2:0];
        fill_d = (fill_q == FILL_TOP) ? fill_q : fill_q + fill_t'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hist_q  <= '0;
      fill_q  <= '0;
      match_q <= 1'b0;
    end else begin
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      match_q <= hit;
    end
  end

  assign match = (MEALY != 0) ? hit : match_q;

  seq_sat_counter #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .inc (hit),
    .cnt (match_cnt),
    .sat (cnt_sat)
  );

endmodule

// File: tb/tb_seq_pattern_fsm.sv
// Bench for seq_pattern_fsm: five configurations share one stimulus stream.
module tb_seq_pattern_fsm;

  localparam int NC = 5;

  logic clk = 1'b0;
  logic rst = 1'b1, clr = 1'b0, din_valid = 1'b0, din = 1'b0;
  logic [3:0] pat4 = 4'b1010;
  logic [1:0] pat2 = 2'b10;
  logic mo[NC];
  logic so[NC];
  logic [7:0] c0, c1, c2;
  logic [1:0] c3;
  logic [2:0] c4;

  always #5 clk = ~clk;

  seq_pattern_fsm #(.LEN(4), .OVERLAP(1), .MEALY(1), .CNT_W(8)) d0 (
    .clk(clk), .rst(rst), .clr(clr), .din_valid(din_valid), .din(din),
    .pattern(pat4), .match(mo[0]), .match_cnt(c0), .cnt_sat(so[0]));
  seq_pattern_fsm #(.LEN(4), .OVERLAP(0), .MEALY(1), .CNT_W(8)) d1 (
    .clk(clk), .rst(rst), .clr(clr), .din_valid(din_valid), .din(din),
    .pattern(pat4), .match(mo[1]), .match_cnt(c1), .cnt_sat(so[1]));
  seq_pattern_fsm #(.LEN(4), .OVERLAP(1), .MEALY(0), .CNT_W(8)) d2 (
    .clk(clk), .rst(rst), .clr(clr), .din_valid(din_valid), .din(din),
    .pattern(pat4), .match(mo[2]), .match_cnt(c2), .cnt_sat(so[2]));
  seq_pattern_fsm #(.LEN(4), .OVERLAP(1), .MEALY(1), .CNT_W(2)) d3 (
    .clk(clk), .rst(rst), .clr(clr), .din_valid(din_valid), .din(din),
    .pattern(pat4), .match(mo[3]), .match_cnt(c3), .cnt_sat(so[3]));
  seq_pattern_fsm #(.LEN(2), .OVERLAP(0), .MEALY(0), .CNT_W(3)) d4 (
    .clk(clk), .rst(rst), .clr(clr), .din_valid(din_valid), .din(din),
    .pattern(pat2), .match(mo[4]), .match_cnt(c4), .cnt_sat(so[4]));

  // per-configuration parameters, mirrored for the reference model
  int cfg_len[NC] = '{4, 4, 4, 4, 2};
  int cfg_ov[NC]  = '{1, 0, 1, 1, 0};
  int cfg_me[NC]  = '{1, 1, 0, 1, 0};
  int cfg_cap[NC] = '{255, 255, 255, 3, 7};

  int nchk = 0;
  int nerr = 0;

  task automatic chk(input string nm, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int get_cnt(input int c);
    case (c)
      0: return int'(c0);
      1: return int'(c1);
      2: return int'(c2);
      3: return int'(c3);
      default: return int'(c4);
    endcase
  endfunction

  // Reference model: a log of every accepted bit plus, per configuration,
  // the log index where the current search window began.
  bit stream[$];
  int start[NC];
  int hits[NC];
  bit prev_hit[NC];

  function automatic int pat_of(input int c);
    return (c < 4) ? int'(pat4) : int'(pat2);
  endfunction

  function automatic bit m_hit(input int c);
    int n, w, l;
    if (rst || clr || !din_valid) return 1'b0;
    l = cfg_len[c];
    n = stream.size();
    if (n - start[c] < l - 1) return 1'b0;
    w = 0;
    for (int k = n - (l - 1); k < n; k++) w = (w << 1) | int'(stream[k]);
    w = (w << 1) | int'(din);
    return w == pat_of(c);
  endfunction

  always @(posedge clk) begin
    bit h[NC];
    for (int c = 0; c < NC; c++) h[c] = m_hit(c);
    if (rst || clr) begin
      for (int c = 0; c < NC; c++) begin
        start[c] = stream.size();
        hits[c] = 0;
        prev_hit[c] = 1'b0;
      end
    end else begin
      if (din_valid) stream.push_back(din);
      for (int c = 0; c < NC; c++) begin
        prev_hit[c] = h[c];
        if (h[c] && hits[c] < cfg_cap[c]) hits[c]++;
        if (h[c] && cfg_ov[c] == 0) start[c] = stream.size();
      end
    end
  end

  // Drive one cycle's inputs at the falling edge; outputs are then checked
  // by the caller shortly afterwards, well before the next rising edge.
  task automatic cyc(input bit r, input bit cl, input bit v, input bit d, input bit use_model);
    @(negedge clk);
    rst = r; clr = cl; din_valid = v; din = d;
    #1;
    if (use_model) begin
      for (int c = 0; c < NC; c++) begin
        bit exp_m;
        exp_m = (cfg_me[c] != 0) ? m_hit(c) : prev_hit[c];
        chk($sformatf("rnd_match_d%0d", c), int'(mo[c]), int'(exp_m));
        chk($sformatf("rnd_cnt_d%0d", c), get_cnt(c), hits[c]);
        chk($sformatf("rnd_sat_d%0d", c), int'(so[c]), int'(hits[c] == cfg_cap[c]));
      end
    end
  endtask

  typedef struct packed {
    bit v; bit d; bit m0; bit m1; bit m2;
    logic [7:0] c0; logic [7:0] c1;
  } vec_t;

  vec_t tbl[7];

  initial begin
    // pattern 1010 on stream 1,0,1,0,1,0 then one idle cycle
    tbl[0] = '{v:1, d:1, m0:0, m1:0, m2:0, c0:0, c1:0};
    tbl[1] = '{v:1, d:0, m0:0, m1:0, m2:0, c0:0, c1:0};
    tbl[2] = '{v:1, d:1, m0:0, m1:0, m2:0, c0:0, c1:0};
    tbl[3] = '{v:1, d:0, m0:1, m1:1, m2:0, c0:0, c1:0};
    tbl[4] = '{v:1, d:1, m0:0, m1:0, m2:1, c0:1, c1:1};
    tbl[5] = '{v:1, d:0, m0:1, m1:0, m2:0, c0:1, c1:1};
    tbl[6] = '{v:0, d:0, m0:0, m1:0, m2:1, c0:2, c1:1};

    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 1, 0, 0);
    for (int c = 0; c < NC; c++) begin
      chk($sformatf("rst_match_d%0d", c), int'(mo[c]), 0);
      chk($sformatf("rst_cnt_d%0d", c), get_cnt(c), 0);
      chk($sformatf("rst_sat_d%0d", c), int'(so[c]), 0);
    end

    for (int i = 0; i < 7; i++) begin
      cyc(0, 0, tbl[i].v, tbl[i].d, 0);
      chk($sformatf("tbl%0d_m_ovl", i), int'(mo[0]), int'(tbl[i].m0));
      chk($sformatf("tbl%0d_m_novl", i), int'(mo[1]), int'(tbl[i].m1));
      chk($sformatf("tbl%0d_m_moore", i), int'(mo[2]), int'(tbl[i].m2));
      chk($sformatf("tbl%0d_cnt_ovl", i), int'(c0), int'(tbl[i].c0));
      chk($sformatf("tbl%0d_cnt_novl", i), int'(c1), int'(tbl[i].c1));
    end

    // Moore timing on 1011: pulse only in the cycle after the accepting edge
    pat4 = 4'b1011;
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 1, 1, 0); chk("moore_s1", int'(mo[2]), 0);
    cyc(0, 0, 1, 0, 0); chk("moore_s2", int'(mo[2]), 0);
    cyc(0, 0, 1, 1, 0); chk("moore_s3", int'(mo[2]), 0);
    cyc(0, 0, 1, 1, 0); chk("moore_s4", int'(mo[2]), 0); chk("mealy_s4", int'(mo[0]), 1);
    cyc(0, 0, 0, 0, 0); chk("moore_after", int'(mo[2]), 1);
    cyc(0, 0, 0, 0, 0); chk("moore_after2", int'(mo[2]), 0);

    // idle gaps are transparent
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 1, 1, 0); chk("gap_s1", int'(mo[0]), 0);
    cyc(0, 0, 1, 0, 0); chk("gap_s2", int'(mo[0]), 0);
    cyc(0, 0, 1, 1, 0); chk("gap_s3", int'(mo[0]), 0);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 1, 0); chk("gap_idle", int'(mo[0]), 0);
    end
    cyc(0, 0, 1, 1, 0); chk("gap_s4", int'(mo[0]), 1);

    // clr mid-pattern discards its own symbol and the partial window
    cyc(0, 0, 1, 1, 0); cyc(0, 0, 1, 0, 0); cyc(0, 0, 1, 1, 0);
    chk("clr_precnt", int'(c0), 1);
    cyc(0, 1, 1, 1, 0); chk("clr_same_cycle", int'(mo[0]), 0);
    cyc(0, 0, 0, 0, 0); chk("clr_cnt", int'(c0), 0); chk("clr_sat", int'(so[0]), 0);
    cyc(0, 0, 1, 1, 0); chk("clr_fresh1", int'(mo[0]), 0);
    cyc(0, 0, 1, 0, 0); cyc(0, 0, 1, 1, 0);
    cyc(0, 0, 1, 1, 0); chk("clr_fresh4", int'(mo[0]), 1);
    // the same with rst
    cyc(0, 0, 1, 1, 0); cyc(0, 0, 1, 0, 0); cyc(0, 0, 1, 1, 0);
    cyc(1, 0, 1, 1, 0); chk("rst_same_cycle", int'(mo[0]), 0);
    cyc(0, 0, 0, 0, 0); chk("rstmid_cnt", int'(c0), 0);
    cyc(0, 0, 1, 1, 0); chk("rst_fresh1", int'(mo[0]), 0);
    cyc(0, 0, 1, 0, 0); cyc(0, 0, 1, 1, 0);
    cyc(0, 0, 1, 1, 0); chk("rst_fresh4", int'(mo[0]), 1);

    // saturation with a self-overlapping pattern on the 2-bit counter
    pat4 = 4'b1111;
    cyc(1, 0, 0, 0, 0);
    for (int i = 1; i <= 10; i++) begin
      int e;
      cyc(0, 0, 1, 1, 0);
      e = (i - 4 > 3) ? 3 : ((i - 4 < 0) ? 0 : i - 4);
      chk($sformatf("sat_m%0d", i), int'(mo[3]), int'(i >= 4));
      chk($sformatf("sat_c%0d", i), int'(c3), e);
      chk($sformatf("sat_s%0d", i), int'(so[3]), int'(i >= 7));
    end
    cyc(0, 0, 0, 0, 0);
    chk("sat_final_cnt", int'(c3), 3);
    chk("sat_final_flag", int'(so[3]), 1);
    chk("sat_final_cnt_wide", int'(c0), 7);

    // randomized stream against the reference model
    cyc(1, 0, 0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      bit r, cl, v;
      if ($urandom_range(0, 199) == 0) begin
        pat4 = 4'($urandom);
        pat2 = 2'($urandom);
      end
      r  = ($urandom_range(0, 79) == 0);
      cl = ($urandom_range(0, 59) == 0);
      v  = ($urandom_range(0, 3) != 0);
      cyc(r, cl, v, 1'($urandom), 1);
    end

    $display("CHECKS %0d ERRORS %0d", nchk, nerr);
    $finish;
  end

endmodule

// File: doc/seq_pattern_fsm.md
Name: seq_pattern_fsm

Overview:
Parametrised serial pattern-detector FSM. It is the generalised successor of the fixed 4-state Mealy/Moore sequence circuits in the niuke set. It detects a runtime-supplied LEN-bit pattern on a valid-qualified serial bit stream, with these options:
- overlap or non-overlap matching;
- Mealy (same-cycle) or Moore (registered) match output;
- a saturating match-event counter.

It sits between a serial input front-end and status/interrupt logic.

Parameters:
LEN, 4, pattern length in bits; legal range 2..32.
OVERLAP, 1, 1 = overlapping matches allowed; 0 = window restarts empty after each match.
MEALY, 1, 1 = match is combinational on the accepting symbol; 0 = match is registered one cycle later.
CNT_W, 8, width of the match counter.

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous active-high reset
clr  input  1  synchronous flush of window, fill count, counter and Moore output
din_valid  input  1  din carries a symbol this cycle
din  input  1  serial data bit
pattern  input  LEN  target pattern; pattern[LEN-1] is the first bit received; must be held stable, a change takes effect the same cycle
match  output  1  one-cycle pulse per detected pattern
match_cnt  output  CNT_W  number of match events since reset/clr, saturating
cnt_sat  output  1  high while match_cnt is all ones

Behaviour:
- Reset (rst=1 at a clk edge):
  - hist=0, fill=0, match_cnt=0, cnt_sat=0, Moore match register=0.
  - Mealy match is 0 while rst is high.
  - rst has priority over everything.
- State consists of:
  - hist[LEN-2:0]: last LEN-1 accepted bits, newest in bit 0;
  - fill: 0..LEN-1, count of valid bits held, saturating at LEN-1.
  - fill acts as the FSM state: states S0..S(LEN-1) mean "k bits collected".
- Accept condition (combinational): hit = din_valid && !clr && (fill == LEN-1) && ({hist, din} == pattern).
- On din_valid && !clr:
  - hist <= {hist[LEN-3:0], din}; for LEN=2, hist <= din.
  - fill <= min(fill+1, LEN-1).
  - Exception when hit && OVERLAP=0: fill <= 0 and hist <= 0.
- din_valid=0: hist and fill hold; no match. Gaps between valid symbols are transparent.
- MEALY=1: match = hit. It is valid in the same cycle as the last pattern bit.
- MEALY=0: match register <= hit. match is high the cycle after the accepting edge, for exactly 1 cycle.
- Counter:
  - On hit, match_cnt <= match_cnt + 1 unless it is already all ones; then it holds.
  - cnt_sat = (match_cnt == all ones), registered together with the count.
- clr=1 (rst=0):
  - Next cycle: hist=0, fill=0, match_cnt=0, cnt_sat=0, Moore register=0.
  - A din_valid symbol in the same cycle is discarded and produces no hit.
- Back-to-back valid symbols every cycle are supported; there is no throughput limit.
- Continuous matches in overlap mode with a self-overlapping pattern (e.g. all ones) pulse match every valid cycle once fill saturates.
- clr or rst asserted mid-pattern: the partial match is lost; detection restarts from S0.

Decomposition:
- Shared package seq_pkg holds:
  - localparams for the LEN legal range (LEN_MIN=2, LEN_MAX=32);
  - a typedef for the fill-state width, clog2(LEN).
- One natural sub-module: seq_sat_counter. It is a CNT_W-bit saturating up-counter with inc, clr and rst inputs and cnt and sat outputs.
- The pattern/window logic stays in the top level.

Test Plan:
1. LEN=4, pattern=4'b1010, OVERLAP=1, MEALY=1, din_valid every cycle, din=1,0,1,0,1,0 -> match high on the 4th and 6th symbol cycles; match_cnt=2 after the 6th.
2. Same stream with OVERLAP=0 -> match only on the 4th symbol; match_cnt=1.
3. MEALY=0, pattern=4'b1011, din=1,0,1,1 -> match high exactly one cycle after the 4th symbol edge and low otherwise; no pulse in the 4th cycle itself.
4. pattern=4'b1011, din=1,0,1 with din_valid dropped for 3 idle cycles, then din=1 -> match on the final valid cycle only; no match during the gap.
5. CNT_W=2, pattern=4'b1111, OVERLAP=1, din=1 for 10 valid cycles -> 7 hits; match_cnt saturates at 3 with cnt_sat=1 from the 3rd hit onward; match keeps pulsing.
6. pattern=4'b1011, din=1,0,1, then clr=1 with din_valid=1, din=1 in the same cycle -> no match; fill and match_cnt are 0 next cycle; a fresh 1,0,1,1 then matches. Repeat with rst in place of clr -> identical.
